// File: rtl/muldiv_pkg.sv
// Shared types and constants for the M-extension multiply/divide sequencer.
package muldiv_pkg;

  localparam int XLEN_DEF = 64;
  localparam int ITER     = 64;

  typedef enum logic [2:0] {
    OP_MUL  = 3'd0,
    OP_DIV  = 3'd1,
    OP_DIVU = 3'd2,
    OP_REM  = 3'd3,
    OP_REMU = 3'd4
  } md_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIX,
    ST_DONE
  } md_state_t;

  localparam logic [XLEN_DEF-1:0] DIV0_Q  = {XLEN_DEF{1'b1}};
  localparam logic [XLEN_DEF-1:0] INT_MIN = {1'b1, {(XLEN_DEF-1){1'b0}}};

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Registered shift-add multiply / restoring divide datapath; one step per enable.
// Multiply: acc accumulates the product. Divide: acc is the remainder, quo the quotient.
module muldiv_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] acc,
  output logic [XLEN-1:0] quo
);

  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] shq_q, shq_d;   // multiplier bits shifting out / dividend shifting into quotient
  logic [XLEN-1:0] opd_q, opd_d;   // shifted multiplicand / fixed divisor
  logic [XLEN:0]   trial;

  // NOTE: every variable written here gets a default first, otherwise paths that skip an assignment infer latches.
  always_comb begin
    acc_d = acc_q;
    shq_d = shq_q;
    opd_d = opd_q;
    // A negative trial difference shows up as bit XLEN set, since {acc,bit} < 2*divisor.
    trial = {acc_q, shq_q[XLEN-1]} - {1'b0, opd_q};
    if (load) begin
      acc_d = '0;
      shq_d = op_a;
      opd_d = op_b;
    end else if (step) begin
      if (is_div) begin
        if (!trial[XLEN]) begin
          acc_d = trial[XLEN-1:0];
          shq_d = {shq_q[XLEN-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[XLEN-2:0], shq_q[XLEN-1]};
          shq_d = {shq_q[XLEN-2:0], 1'b0};
        end
      end else begin
        acc_d = acc_q + (shq_q[0] ? opd_q : '0);
        shq_d = shq_q >> 1;
        opd_d = opd_q << 1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      shq_q <= '0;
      opd_q <= '0;
    end else begin
      acc_q <= acc_d;
      shq_q <= shq_d;
      opd_q <= opd_d;
    end
  end

  assign acc = acc_q;
  assign quo = shq_q;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MUL/DIV/DIVU/REM/REMU sequencer with valid/ready handshake and flush.
// Optional MULDIV_EARLY_OUT_EN: special cases skip the 64 CALC iterations.
import muldiv_pkg::*;

module muldiv_seq #(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  md_state_t       state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_signed, is_div;
  logic            prep_div0, prep_ovf;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] iter_acc, iter_quo;
  logic [XLEN-1:0] fix_res;

  assign is_signed = op_is_signed(op_q);
  assign is_div    = op_is_div(op_q);
  assign prep_div0 = is_div && (b_q == '0);
  assign prep_ovf  = is_signed && (a_q == INT_MIN) && (b_q == DIV0_Q);
  assign abs_a     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
  assign abs_b     = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == ST_PREP),
    .step   (state_q == ST_CALC),
    .is_div (is_div),
    .op_a   (abs_a),
    .op_b   (abs_b),
    .acc    (iter_acc),
    .quo    (iter_quo)
  );

  // Sign correction and special-case overrides applied on the way out of FIX.
  always_comb begin
    fix_res = '0;
    case (op_q)
      OP_MUL: fix_res = iter_acc;
      OP_DIV, OP_DIVU: begin
        if (div0_q)       fix_res = DIV0_Q;
        else if (ovf_q)   fix_res = a_q;
        else if (q_neg_q) fix_res = -iter_quo;
        else              fix_res = iter_quo;
      end
      OP_REM, OP_REMU: begin
        if (div0_q)       fix_res = a_q;
        else if (ovf_q)   fix_res = '0;
        else if (r_neg_q) fix_res = -iter_acc;
        else              fix_res = iter_acc;
      end
      default: fix_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    counter_d = counter_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        q_neg_d   = is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1]);
        r_neg_d   = is_signed && a_q[XLEN-1];
        div0_d    = prep_div0;
        ovf_d     = prep_ovf;
        counter_d = '0;
        state_d   = ST_CALC;
`ifdef MULDIV_EARLY_OUT_EN
        // FIX forms the special result from the flags, so the result is valid two edges after accept.
        if (prep_div0 || prep_ovf || ((op_q == OP_MUL) && ((a_q == '0) || (b_q == '0))))
          state_d = ST_FIX;
`endif
      end
      ST_CALC: begin
        if (counter_q == {CNT_W{1'b1}}) state_d = ST_FIX;
        else                            counter_d = counter_q + CNT_W'(1);
      end
      ST_FIX: begin
        result_d = fix_res;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  // NOTE: operand/flag registers are reset too so every output is defined straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      counter_q <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      counter_q <= counter_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

endmodule
